// File: rtl/smc_mem_resp_pkg.sv
// Shared SMC definitions: responder FSM states, violation flag indices and read-latency bounds.
package smc_defs_lite;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_RD_WAIT,
    ST_RD_DRIVE,
    ST_WR_ACT
  } smc_state_e;

  localparam int unsigned VIOL_OVERLAP  = 0;
  localparam int unsigned VIOL_SHORT_WE = 1;
  localparam int unsigned VIOL_ADDR_CHG = 2;
  localparam int unsigned VIOL_CS_REL   = 3;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 15;

  // Value loaded into the read-latency down-counter; out-of-range latencies are clamped.
  function automatic logic [3:0] lat_load(input int unsigned lat);
    if (lat < RD_LAT_MIN)
      return '0;
    else if (lat > RD_LAT_MAX)
      return 4'(RD_LAT_MAX - 1);
    else
      return 4'(lat - 1);
  endfunction

endpackage

// File: rtl/smc_mem_resp_if.sv
// SMC asynchronous-memory bus between the static memory controller and a responder.
interface smc_mem_resp_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              n_cs;
  logic              n_oe;
  logic              n_we;
  logic [3:0]        n_be;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              rdata_oe;

  modport master (
    output n_cs, n_oe, n_we, n_be, addr, wdata,
    input  rdata, rdata_oe
  );

  modport slave (
    input  n_cs, n_oe, n_we, n_be, addr, wdata,
    output rdata, rdata_oe
  );
endinterface

// File: rtl/smc_mem_resp_ram.sv
// Word-addressed storage: synchronous byte-lane writes, registered read port.
module smc_mem_resp_ram #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              sys_clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge sys_clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i])
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/smc_mem_resp.sv
// SMC memory responder: decodes CS/OE/WE strobes into reads and writes of a local RAM,
// counts completed accesses and flags protocol violations.
module smc_mem_resp
  import smc_defs_lite::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                sys_clk,
  input  logic                n_sys_reset,
  smc_mem_resp_if.slave       smc,
  input  logic [3:0]          cfg_min_we,
  input  logic                viol_clr,
  output logic [3:0]          viol,
  output logic [15:0]         rd_cnt,
  output logic [15:0]         wr_cnt,
  output logic                busy
);

  localparam logic [3:0] LAT_LOAD = lat_load(RD_LAT);

  smc_state_e        state, nxt_state;
  logic [3:0]        lat_cnt, nxt_lat;
  logic [3:0]        wid_cnt, nxt_wid;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       wbuf;
  logic [3:0]        wbe;
  logic [31:0]       ram_q;
  logic              ld_addr, cap_w, rd_done, wr_commit, ram_re;
  logic [3:0]        viol_set;
  logic              strobe, overlap, addr_chg;

  always_ff @(posedge sys_clk) begin
    if (!n_sys_reset)
      state <= ST_IDLE;
    else
      state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    nxt_lat   = lat_cnt;
    nxt_wid   = wid_cnt;
    ld_addr   = 1'b0;
    cap_w     = 1'b0;
    rd_done   = 1'b0;
    wr_commit = 1'b0;
    ram_re    = 1'b0;
    viol_set  = '0;
    strobe    = !smc.n_oe || !smc.n_we;
    overlap   = !smc.n_oe && !smc.n_we;
    addr_chg  = smc.addr != lat_addr;
    case (state)
      ST_IDLE: begin
        if (!smc.n_cs)
          nxt_state = ST_SEL;
      end
      ST_SEL: begin
        if (smc.n_cs) begin
          nxt_state = ST_IDLE;
        end else if (overlap) begin
          viol_set[VIOL_OVERLAP] = 1'b1;
        end else if (!smc.n_oe) begin
          nxt_state = ST_RD_WAIT;
          ld_addr   = 1'b1;
          nxt_lat   = LAT_LOAD;
        end else if (!smc.n_we) begin
          nxt_state = ST_WR_ACT;
          ld_addr   = 1'b1;
          nxt_wid   = '0;
          cap_w     = 1'b1;
        end
      end
      default: begin
        // CS release and strobe overlap take priority over every active state.
        if (smc.n_cs) begin
          nxt_state = ST_IDLE;
          if (strobe)
            viol_set[VIOL_CS_REL] = 1'b1;
        end else if (overlap) begin
          nxt_state = ST_SEL;
          viol_set[VIOL_OVERLAP] = 1'b1;
        end else begin
          case (state)
            ST_RD_WAIT: begin
              if (smc.n_oe) begin
                nxt_state = ST_SEL;
              end else begin
                if (addr_chg)
                  viol_set[VIOL_ADDR_CHG] = 1'b1;
                if (lat_cnt == '0) begin
                  nxt_state = ST_RD_DRIVE;
                  ram_re    = 1'b1;
                end else begin
                  nxt_lat = lat_cnt - 4'd1;
                end
              end
            end
            ST_RD_DRIVE: begin
              if (smc.n_oe) begin
                nxt_state = ST_SEL;
                rd_done   = 1'b1;
              end else if (addr_chg) begin
                nxt_state = ST_RD_WAIT;
                ld_addr   = 1'b1;
                nxt_lat   = LAT_LOAD;
                rd_done   = 1'b1;
              end
            end
            ST_WR_ACT: begin
              if (smc.n_we) begin
                nxt_state = ST_SEL;
                if (({1'b0, wid_cnt} + 5'd1) >= {1'b0, cfg_min_we})
                  wr_commit = 1'b1;
                else
                  viol_set[VIOL_SHORT_WE] = 1'b1;
              end else begin
                cap_w = 1'b1;
                if (wid_cnt != 4'hF)
                  nxt_wid = wid_cnt + 4'd1;
                if (addr_chg)
                  viol_set[VIOL_ADDR_CHG] = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!n_sys_reset) begin
      lat_addr <= '0;
      lat_cnt  <= '0;
      wid_cnt  <= '0;
      wbuf     <= '0;
      wbe      <= '0;
      viol     <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
    end else begin
      if (ld_addr)
        lat_addr <= smc.addr;
      lat_cnt <= nxt_lat;
      wid_cnt <= nxt_wid;
      if (cap_w) begin
        wbuf <= smc.wdata;
        wbe  <= ~smc.n_be;
      end
      viol <= (viol & {4{~viol_clr}}) | viol_set;
      if (rd_done)
        rd_cnt <= rd_cnt + 16'd1;
      if (wr_commit)
        wr_cnt <= wr_cnt + 16'd1;
    end
  end

  // Reset gates the RAM strobes so an access cut short by reset never lands.
  smc_mem_resp_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .sys_clk (sys_clk),
    .we      (wr_commit && n_sys_reset),
    .be      (wbe),
    .waddr   (lat_addr),
    .wdata   (wbuf),
    .re      (ram_re && n_sys_reset),
    .raddr   (lat_addr),
    .rdata   (ram_q)
  );

  assign smc.rdata_oe = (state == ST_RD_DRIVE);
  assign smc.rdata    = smc.rdata_oe ? ram_q : '0;
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_smc_mem_resp.sv
// Directed self-checking bench for smc_mem_resp.
module tb_smc_mem_resp;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned RD_LAT = 3;

  logic        sys_clk = 1'b0;
  logic        n_sys_reset;
  logic [3:0]  cfg_min_we;
  logic        viol_clr;
  logic [3:0]  viol;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
  logic        busy;

  int checks = 0;
  int failures = 0;

  smc_mem_resp_if #(.ADDR_W(ADDR_W)) smc ();

  smc_mem_resp #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .sys_clk     (sys_clk),
    .n_sys_reset (n_sys_reset),
    .smc         (smc),
    .cfg_min_we  (cfg_min_we),
    .viol_clr    (viol_clr),
    .viol        (viol),
    .rd_cnt      (rd_cnt),
    .wr_cnt      (wr_cnt),
    .busy        (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic bus_idle();
    smc.n_cs  = 1'b1;
    smc.n_oe  = 1'b1;
    smc.n_we  = 1'b1;
    smc.n_be  = 4'hF;
    smc.addr  = '0;
    smc.wdata = '0;
  endtask

  // Ticks until rdata_oe rises, bounded; returns the number of ticks taken.
  task automatic wait_oe(output int n);
    n = 0;
    while (smc.rdata_oe !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] nbe,
                          input int low_cycles);
    smc.n_cs = 1'b0;
    smc.addr = a;
    tick();
    smc.n_we  = 1'b0;
    smc.wdata = d;
    smc.n_be  = nbe;
    for (int i = 0; i < low_cycles; i++) tick();
    smc.n_we = 1'b1;
    tick();
    bus_idle();
    tick();
  endtask

  task automatic do_read(input string tag, input logic [5:0] a, input logic [31:0] exp);
    int n;
    smc.n_cs = 1'b0;
    smc.addr = a;
    tick();
    smc.n_oe = 1'b0;
    tick();
    chk({tag, "_wait_oe"}, 32'(smc.rdata_oe), 32'd0);
    wait_oe(n);
    chk({tag, "_lat"}, 32'(n), 32'(RD_LAT));
    chk({tag, "_data"}, smc.rdata, exp);
    smc.n_oe = 1'b1;
    tick();
    chk({tag, "_rdata_off"}, smc.rdata, 32'd0);
    bus_idle();
    tick();
  endtask

  initial begin
    int n;
    bus_idle();
    n_sys_reset = 1'b0;
    cfg_min_we  = 4'd2;
    viol_clr    = 1'b0;
    repeat (3) tick();
    chk("rst_rdata_oe", 32'(smc.rdata_oe), 32'd0);
    chk("rst_rdata", smc.rdata, 32'd0);
    chk("rst_viol", 32'(viol), 32'd0);
    chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
    chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    n_sys_reset = 1'b1;
    tick();

    // Basic write/read round trip
    do_write(6'd5, 32'hA5A5_1234, 4'h0, 3);
    chk("wr1_cnt", 32'(wr_cnt), 32'd1);
    chk("wr1_viol", 32'(viol), 32'd0);
    do_read("rd5", 6'd5, 32'hA5A5_1234);
    chk("rd1_cnt", 32'(rd_cnt), 32'd1);

    // Partial byte-lane write over zero
    do_write(6'd7, 32'h0000_0000, 4'h0, 2);
    do_write(6'd7, 32'hFFFF_FFFF, 4'b1100, 2);
    chk("be_wr_cnt", 32'(wr_cnt), 32'd3);
    do_read("rd7", 6'd7, 32'h0000_FFFF);
    chk("be_rd_cnt", 32'(rd_cnt), 32'd2);

    // Short write strobe
    cfg_min_we = 4'd3;
    do_write(6'd5, 32'hDEAD_BEEF, 4'h0, 1);
    chk("short_viol", 32'(viol), 32'h2);
    chk("short_wr_cnt", 32'(wr_cnt), 32'd3);
    do_read("rd5_kept", 6'd5, 32'hA5A5_1234);
    chk("short_viol_sticky", 32'(viol), 32'h2);
    viol_clr = 1'b1;
    tick();
    viol_clr = 1'b0;
    chk("viol_clr", 32'(viol), 32'd0);

    // Strobe width exactly at the minimum commits
    do_write(6'd6, 32'h1111_2222, 4'h0, 3);
    chk("minw_wr_cnt", 32'(wr_cnt), 32'd4);
    chk("minw_viol", 32'(viol), 32'd0);
    do_read("rd6", 6'd6, 32'h1111_2222);

    // Address change mid-write: flagged, write still lands at latched address
    smc.n_cs = 1'b0;
    smc.addr = 6'd9;
    tick();
    smc.n_we  = 1'b0;
    smc.wdata = 32'h0BAD_F00D;
    smc.n_be  = 4'h0;
    tick();
    smc.addr = 6'd10;
    tick();
    tick();
    smc.n_we = 1'b1;
    tick();
    chk("achg_viol", 32'(viol), 32'h4);
    chk("achg_wr_cnt", 32'(wr_cnt), 32'd5);
    bus_idle();
    tick();
    do_read("rd9", 6'd9, 32'h0BAD_F00D);
    viol_clr = 1'b1;
    tick();
    viol_clr = 1'b0;

    // OE/WE overlap, then CS release with OE low
    smc.n_cs = 1'b0;
    smc.addr = 6'd5;
    tick();
    smc.n_oe  = 1'b0;
    smc.n_we  = 1'b0;
    smc.wdata = 32'h5555_5555;
    smc.n_be  = 4'h0;
    tick();
    chk("ovl_viol", 32'(viol), 32'h1);
    chk("ovl_busy", 32'(busy), 32'd1);
    smc.n_oe = 1'b1;
    smc.n_we = 1'b1;
    tick();
    chk("ovl_wr_cnt", 32'(wr_cnt), 32'd5);
    chk("ovl_rd_cnt", 32'(rd_cnt), 32'd5);
    smc.n_oe = 1'b0;
    tick();
    smc.n_cs = 1'b1;
    tick();
    chk("csrel_viol", 32'(viol), 32'h9);
    chk("csrel_busy", 32'(busy), 32'd0);
    chk("csrel_rd_cnt", 32'(rd_cnt), 32'd5);
    bus_idle();
    viol_clr = 1'b1;
    tick();
    viol_clr = 1'b0;
    do_read("rd5_after_ovl", 6'd5, 32'hA5A5_1234);

    // Back-to-back reads with CS held, after a reset that keeps RAM contents
    do_write(6'd1, 32'h0000_0011, 4'h0, 3);
    do_write(6'd2, 32'h0000_0022, 4'h0, 3);
    do_write(6'd3, 32'h0000_0033, 4'h0, 3);
    n_sys_reset = 1'b0;
    tick();
    n_sys_reset = 1'b1;
    chk("rst2_wr_cnt", 32'(wr_cnt), 32'd0);
    smc.n_cs = 1'b0;
    smc.addr = 6'd1;
    tick();
    smc.n_oe = 1'b0;
    tick();
    wait_oe(n);
    chk("b2b1_lat", 32'(n), 32'(RD_LAT));
    chk("b2b1_data", smc.rdata, 32'h0000_0011);
    smc.addr = 6'd2;
    tick();
    chk("b2b2_rd_cnt", 32'(rd_cnt), 32'd1);
    chk("b2b2_oe_gap", 32'(smc.rdata_oe), 32'd0);
    wait_oe(n);
    chk("b2b2_lat", 32'(n), 32'(RD_LAT));
    chk("b2b2_data", smc.rdata, 32'h0000_0022);
    smc.addr = 6'd3;
    tick();
    wait_oe(n);
    chk("b2b3_data", smc.rdata, 32'h0000_0033);
    smc.n_oe = 1'b1;
    tick();
    chk("b2b_rd_cnt", 32'(rd_cnt), 32'd3);
    chk("b2b_viol", 32'(viol), 32'd0);

    // Reset during a read wait
    smc.n_oe = 1'b0;
    tick();
    chk("rstrd_busy_pre", 32'(busy), 32'd1);
    n_sys_reset = 1'b0;
    tick();
    chk("rstrd_oe", 32'(smc.rdata_oe), 32'd0);
    chk("rstrd_rd_cnt", 32'(rd_cnt), 32'd0);
    chk("rstrd_busy", 32'(busy), 32'd0);
    bus_idle();
    n_sys_reset = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
